// File: rtl/beam_thresh_loader.sv
// Per-beam threshold shadow table with a serial two's-complement load sweep into the dual-beam array.
// Optional feature macro THRESH_READBACK_EN: active-table readback port (rd_addr_i / rd_data_o).
module beam_thresh_loader #(
    parameter int unsigned NBEAMS      = 48,
    parameter int unsigned THRESH_BITS = 18
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(NBEAMS)-1:0] wr_addr_i,
    input  logic [THRESH_BITS-1:0]    wr_data_i,
    input  logic                      commit_i,
`ifdef THRESH_READBACK_EN
    input  logic [$clog2(NBEAMS)-1:0] rd_addr_i,
    output logic [THRESH_BITS-1:0]    rd_data_o,
`endif
    output logic                      busy_o,
    output logic                      done_o,
    output logic [THRESH_BITS-1:0]    thresh_o,
    output logic [NBEAMS-1:0]         thresh_ce_o,
    output logic                      update_o
);
    localparam int unsigned AW = $clog2(NBEAMS);
    localparam int unsigned TW = THRESH_BITS;
    localparam logic [AW:0]   NB_LIM   = (AW+1)'(NBEAMS);
    localparam logic [AW-1:0] IDX_LAST = AW'(NBEAMS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic              r_pending;
    logic              r_busy;
    logic              r_done;
    logic [TW-1:0]     r_thresh;
    logic [NBEAMS-1:0] r_ce;
    logic              r_update;
    logic [TW-1:0]     r_shadow [NBEAMS];

    logic              w_wr_ok;
    logic [AW-1:0]     w_nidx;
    logic [AW-1:0]     w_ld_idx;
    logic [TW-1:0]     w_ld_val;
    logic              w_ld_fire;

    function automatic logic [TW-1:0] f_neg(input logic [TW-1:0] v);
        return ~v + TW'(1);
    endfunction

    assign w_wr_ok   = ({1'b0, wr_addr_i} < NB_LIM);
    assign w_nidx    = r_idx + AW'(1);
    assign w_ld_idx  = (r_state == S_IDLE) ? '0 : w_nidx;
    assign w_ld_val  = r_shadow[w_ld_idx];
    // A beam's value is captured at the edge that raises its enable, so a same-edge write is not seen.
    assign w_ld_fire = ((r_state == S_IDLE) && (commit_i || r_pending)) ||
                       ((r_state == S_LOAD) && (r_idx != IDX_LAST));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int b = 0; b < NBEAMS; b++) r_shadow[b] <= '1;
        end else if (wr_en_i && w_wr_ok) begin
            r_shadow[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_thresh  <= '0;
            r_ce      <= '0;
            r_update  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_update <= 1'b0;
            r_ce     <= '0;
            if (w_ld_fire) begin
                r_thresh <= f_neg(w_ld_val);
                r_ce     <= NBEAMS'(1) << w_ld_idx;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ld_fire) begin
                        r_state   <= S_LOAD;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (commit_i) r_pending <= 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_update <= 1'b1;
                        r_state  <= S_UPDATE;
                    end else begin
                        r_idx <= w_nidx;
                    end
                end
                S_UPDATE: begin
                    if (commit_i) r_pending <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef THRESH_READBACK_EN
    logic [TW-1:0] r_loaded [NBEAMS];
    logic [TW-1:0] r_active [NBEAMS];
    logic [TW-1:0] r_rd_data;
    logic          w_rd_ok;

    assign w_rd_ok = ({1'b0, rd_addr_i} < NB_LIM);

    // Values captured during the sweep become visible only once the broadcast update is issued.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int b = 0; b < NBEAMS; b++) begin
                r_loaded[b] <= '1;
                r_active[b] <= '1;
            end
            r_rd_data <= '0;
        end else begin
            if (w_ld_fire) r_loaded[w_ld_idx] <= w_ld_val;
            if (r_state == S_UPDATE) begin
                for (int b = 0; b < NBEAMS; b++) r_active[b] <= r_loaded[b];
            end
            r_rd_data <= w_rd_ok ? r_active[rd_addr_i] : '0;
        end
    end

    assign rd_data_o = r_rd_data;
`endif

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign thresh_o    = r_thresh;
    assign thresh_ce_o = r_ce;
    assign update_o    = r_update;

endmodule
